// File: rtl/task_graph_mapper.sv
// Streams a weighted adjacency matrix, counts upper-triangle edges and places each
// newly seen task on the next free mesh PE, emitting placement records through a FIFO.
//
// state | meaning
// IDLE  | waiting for start after reset
// SCAN  | accepting matrix entries
// FLUSH | last entry taken, draining placement FIFO
// DONE  | graph complete, results held until start
module task_graph_mapper #(
  parameter int NUM_TASKS = 4,
  parameter int WEIGHT_W  = 32,
  parameter int MESH_X    = 2,
  parameter int MESH_Y    = 2,
  parameter int OUT_DEPTH = 4,
  localparam int IDX_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1,
  localparam int X_W   = (MESH_X > 1) ? $clog2(MESH_X) : 1,
  localparam int Y_W   = (MESH_Y > 1) ? $clog2(MESH_Y) : 1
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        start,
  input  logic                        edge_valid,
  output logic                        edge_ready,
  input  logic [IDX_W-1:0]            edge_row,
  input  logic [IDX_W-1:0]            edge_col,
  input  logic [WEIGHT_W-1:0]         edge_weight,
  input  logic                        edge_last,
  output logic                        map_valid,
  input  logic                        map_ready,
  output logic [IDX_W-1:0]            map_task,
  output logic [X_W-1:0]              map_pe_x,
  output logic [Y_W-1:0]              map_pe_y,
  output logic                        map_is_root,
  output logic [2*IDX_W:0]            edge_count,
  output logic [WEIGHT_W+2*IDX_W-1:0] total_weight,
  output logic                        overflow,
  output logic                        done
);

  localparam int PE_N  = MESH_X * MESH_Y;
  localparam int N_W   = $clog2(PE_N + 1);
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int REC_W = IDX_W + X_W + Y_W + 1;
  localparam int EC_W  = 2 * IDX_W + 1;
  localparam int TW_W  = WEIGHT_W + 2 * IDX_W;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [REC_W-1:0]     fifo_q [OUT_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr, wr_ptr_1;
  logic [CNT_W-1:0]     count;
  logic [NUM_TASKS-1:0] seen;
  logic [N_W-1:0]       pe_next, pe_row, pe_col;
  logic                 accept, is_edge, row_new, col_new, row_place, col_place;
  logic                 lost, clear, pop;
  logic [REC_W-1:0]     rec_row, rec_col;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [X_W+Y_W-1:0] pe_xy(input logic [N_W-1:0] n);
    int v;
    v = int'(n);
    return {X_W'(v % MESH_X), Y_W'(v / MESH_X)};
  endfunction

  // Two records may be pushed per edge, so input stalls unless two slots are free.
  assign edge_ready = (state_q == SCAN) && ((CNT_W'(OUT_DEPTH) - count) >= CNT_W'(2));
  assign map_valid  = (count != '0);
  assign {map_task, map_pe_x, map_pe_y, map_is_root} = fifo_q[rd_ptr];
  assign done       = (state_q == DONE);

  always_comb begin
    accept    = edge_valid && edge_ready;
    is_edge   = accept && (edge_weight != '0) && (edge_row < edge_col);
    row_new   = !seen[edge_row];
    col_new   = !seen[edge_col];
    pe_row    = pe_next;
    row_place = is_edge && row_new && (pe_row < N_W'(PE_N));
    pe_col    = pe_row + N_W'(row_place);
    col_place = is_edge && col_new && (pe_col < N_W'(PE_N));
    lost      = is_edge && ((row_new && !row_place) || (col_new && !col_place));
    // only the row of the very first edge can be the root
    rec_row   = {edge_row, pe_xy(pe_row), (edge_count == '0)};
    rec_col   = {edge_col, pe_xy(pe_col), 1'b0};
    wr_ptr_1  = ptr_inc(wr_ptr);
    pop       = map_valid && map_ready;
    clear     = start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (accept && edge_last) state_d = FLUSH;
      FLUSH:   if (count == '0) state_d = DONE;
      DONE:    if (start) state_d = SCAN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      edge_count   <= '0;
      total_weight <= '0;
      overflow     <= 1'b0;
      seen         <= '0;
      pe_next      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        edge_count   <= '0;
        total_weight <= '0;
        overflow     <= 1'b0;
        seen         <= '0;
        pe_next      <= '0;
      end else if (is_edge) begin
        edge_count     <= edge_count + EC_W'(1);
        total_weight   <= total_weight + TW_W'(edge_weight);
        seen[edge_row] <= 1'b1;
        seen[edge_col] <= 1'b1;
        pe_next        <= pe_col + N_W'(col_place);
        if (lost) overflow <= 1'b1;
      end
      if (row_place) fifo_q[wr_ptr] <= rec_row;
      if (col_place) fifo_q[row_place ? wr_ptr_1 : wr_ptr] <= rec_col;
      if (row_place && col_place) wr_ptr <= ptr_inc(wr_ptr_1);
      else if (row_place || col_place) wr_ptr <= wr_ptr_1;
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(row_place) + CNT_W'(col_place) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_task_graph_mapper.sv
// Bench for task_graph_mapper: a 2x2-mesh and a 1x2-mesh instance driven with directed
// and random matrix streams, checked against a graph-level placement model.
`timescale 1ns/1ps
module tb_task_graph_mapper;

  typedef struct packed {
    logic [1:0] tsk;
    logic       x;
    logic       y;
    logic       root;
  } rec_t;

  typedef struct {
    int     row;
    int     col;
    longint w;
    bit     last;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start_s [2];
  logic        ev [2], er [2], el [2], mv [2], mr [2];
  logic        mx_s [2], my_s [2], mroot [2], ovf [2], dn [2];
  logic [1:0]  erow [2], ecol [2], mtask [2];
  logic [31:0] ew [2];
  logic [4:0]  ecnt [2];
  logic [35:0] etot [2];

  int     n_total = 0;
  int     n_bad   = 0;
  ent_t   ents[$];
  rec_t   exp_rec [2][32];
  int     exp_len [2];
  int     exp_cnt [2];
  longint exp_tot [2];
  int     exp_ovf [2];
  int     tok [2];
  int     acc_cnt [2];
  int     rmode [2];

  int     rd [2];
  int     seen_tok [2];
  bit     prev_hold [2];
  rec_t   prev_rec [2];

  always #5 clk = ~clk;

  task_graph_mapper #(.MESH_X(2), .MESH_Y(2)) dut0 (
    .clk(clk), .rst_b(rst_b), .start(start_s[0]),
    .edge_valid(ev[0]), .edge_ready(er[0]), .edge_row(erow[0]), .edge_col(ecol[0]),
    .edge_weight(ew[0]), .edge_last(el[0]),
    .map_valid(mv[0]), .map_ready(mr[0]), .map_task(mtask[0]), .map_pe_x(mx_s[0]),
    .map_pe_y(my_s[0]), .map_is_root(mroot[0]), .edge_count(ecnt[0]),
    .total_weight(etot[0]), .overflow(ovf[0]), .done(dn[0]));

  task_graph_mapper #(.MESH_X(1), .MESH_Y(2)) dut1 (
    .clk(clk), .rst_b(rst_b), .start(start_s[1]),
    .edge_valid(ev[1]), .edge_ready(er[1]), .edge_row(erow[1]), .edge_col(ecol[1]),
    .edge_weight(ew[1]), .edge_last(el[1]),
    .map_valid(mv[1]), .map_ready(mr[1]), .map_task(mtask[1]), .map_pe_x(mx_s[1]),
    .map_pe_y(my_s[1]), .map_is_root(mroot[1]), .edge_count(ecnt[1]),
    .total_weight(etot[1]), .overflow(ovf[1]), .done(dn[1]));

  function automatic void chk(string nm, int d, longint act, longint expv);
    n_total++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, expv);
    end
  endfunction

  // Graph-level reference: walk the entry list, place first appearances in PE order.
  task automatic run_model(input int d, input int n_ent);
    int pe_n, mxx, n, t;
    bit seen [4];
    rec_t r;
    pe_n = (d == 0) ? 4 : 2;
    mxx  = (d == 0) ? 2 : 1;
    n = 0;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    exp_len[d] = 0; exp_cnt[d] = 0; exp_tot[d] = 0; exp_ovf[d] = 0;
    for (int i = 0; i < n_ent; i++) begin
      if (ents[i].w != 0 && ents[i].row < ents[i].col) begin
        exp_cnt[d]++;
        exp_tot[d] += ents[i].w;
        for (int s = 0; s < 2; s++) begin
          t = (s == 0) ? ents[i].row : ents[i].col;
          if (!seen[t]) begin
            seen[t] = 1;
            if (n < pe_n) begin
              r.tsk  = 2'(t);
              r.x    = 1'(n % mxx);
              r.y    = 1'(n / mxx);
              r.root = (s == 0) && (exp_cnt[d] == 1);
              exp_rec[d][exp_len[d]] = r;
              exp_len[d]++;
              n++;
            end else exp_ovf[d] = 1;
          end
        end
      end
    end
    tok[d]++;
  endtask

  task automatic graph1();
    ent_t e;
    ents.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e.row = r; e.col = c; e.last = (r == 3 && c == 3);
        if ((r == 0 && c == 1) || (r == 1 && c == 0)) e.w = 5;
        else if ((r == 0 && c == 3) || (r == 3 && c == 0)) e.w = 7;
        else if ((r == 1 && c == 2) || (r == 2 && c == 1)) e.w = 6;
        else e.w = 0;
        ents.push_back(e);
      end
  endtask

  task automatic zero_graph();
    ent_t e;
    ents.delete();
    for (int i = 0; i < 16; i++) begin
      e.row = i / 4; e.col = i % 4; e.w = 0; e.last = (i == 15);
      ents.push_back(e);
    end
  endtask

  task automatic rand_graph();
    ent_t e;
    int len;
    ents.delete();
    len = $urandom_range(3, 16);
    for (int i = 0; i < len; i++) begin
      e.row = $urandom_range(0, 3);
      e.col = $urandom_range(0, 3);
      e.w   = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom);
      e.last = (i == len - 1);
      ents.push_back(e);
    end
  endtask

  task automatic begin_graph(input int d);
    @(posedge clk); #1 start_s[d] = 1'b1;
    @(posedge clk); #1 start_s[d] = 1'b0;
  endtask

  task automatic send_entries(input int d, input int n_ent, input int start_at);
    int waitc;
    acc_cnt[d] = 0;
    for (int i = 0; i < n_ent; i++) begin
      waitc   = 0;
      erow[d] = 2'(ents[i].row);
      ecol[d] = 2'(ents[i].col);
      ew[d]   = 32'(ents[i].w);
      el[d]   = ents[i].last;
      ev[d]   = 1'b1;
      if (i == start_at) start_s[d] = 1'b1;
      @(negedge clk);
      while (!er[d] && waitc < 300) begin
        @(negedge clk);
        waitc++;
      end
      if (!er[d]) begin
        chk("edge_ready_timeout", d, 0, 1);
        ev[d] = 1'b0; start_s[d] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      acc_cnt[d]++;
      start_s[d] = 1'b0;
    end
    ev[d] = 1'b0;
    el[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int c;
    c = 0;
    while (!dn[d] && c < 800) begin
      @(negedge clk);
      c++;
    end
    chk("done", d, dn[d], 1);
  endtask

  task automatic check_final(input int d);
    chk("edge_count", d, ecnt[d], exp_cnt[d]);
    chk("total_weight", d, etot[d], exp_tot[d]);
    chk("overflow", d, ovf[d], exp_ovf[d]);
    chk("records_out", d, rd[d], exp_len[d]);
    chk("map_valid_idle", d, mv[d], 0);
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_edge_ready", d, er[d], 0);
    chk("rst_map_valid", d, mv[d], 0);
    chk("rst_edge_count", d, ecnt[d], 0);
    chk("rst_total_weight", d, etot[d], 0);
    chk("rst_overflow", d, ovf[d], 0);
    chk("rst_done", d, dn[d], 0);
  endtask

  // Record scoreboard and hold-stability check for both instances.
  always @(negedge clk) begin
    rec_t a;
    for (int d = 0; d < 2; d++) begin
      if (seen_tok[d] != tok[d]) begin
        seen_tok[d] = tok[d];
        rd[d] = 0;
      end
      if (!rst_b) prev_hold[d] = 0;
      else begin
        a = {mtask[d], mx_s[d], my_s[d], mroot[d]};
        if (prev_hold[d]) chk("map_hold_stable", d, {mv[d], a}, {1'b1, prev_rec[d]});
        if (mv[d] && mr[d]) begin
          n_total++;
          if (rd[d] >= exp_len[d]) begin
            n_bad++;
            $display("FAIL extra_record dut%0d: got record %0h expected none", d, a);
          end else begin
            if (a != exp_rec[d][rd[d]]) begin
              n_bad++;
              $display("FAIL record dut%0d #%0d: got %0h expected %0h", d, rd[d], a,
                       exp_rec[d][rd[d]]);
            end
            rd[d]++;
          end
        end
        prev_hold[d] = mv[d] && !mr[d];
        prev_rec[d]  = a;
      end
    end
  end

  initial begin
    mr[0] = 1'b1; mr[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        case (rmode[d])
          0:       mr[d] = 1'b1;
          1:       mr[d] = 1'b0;
          default: mr[d] = 1'($urandom_range(0, 1));
        endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 0; ev[d] = 0; el[d] = 0; erow[d] = 0; ecol[d] = 0; ew[d] = 0;
      exp_len[d] = 0; tok[d] = 0; rmode[d] = 0; acc_cnt[d] = 0;
      rd[d] = 0; seen_tok[d] = 0; prev_hold[d] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk); #1 rst_b = 1'b1;

    // graph 1 with free-flowing output; model pinned against hand-derived records
    graph1();
    run_model(0, 16);
    chk("model_len", 0, exp_len[0], 4);
    chk("model_rec0", 0, exp_rec[0][0], 5'b00_0_0_1);
    chk("model_rec1", 0, exp_rec[0][1], 5'b01_1_0_0);
    chk("model_rec2", 0, exp_rec[0][2], 5'b11_0_1_0);
    chk("model_rec3", 0, exp_rec[0][3], 5'b10_1_1_0);
    begin_graph(0);
    send_entries(0, 16, -1);
    wait_done(0);
    check_final(0);
    chk("g1_edge_count", 0, ecnt[0], 3);
    chk("g1_total_weight", 0, etot[0], 18);

    // consumer stalled: input must stop after the fourth entry
    rmode[0] = 1;
    run_model(0, 16);
    begin_graph(0);
    fork
      send_entries(0, 16, -1);
      begin
        repeat (15) @(negedge clk);
        chk("stall_accepted", 0, acc_cnt[0], 4);
        chk("stall_edge_ready", 0, er[0], 0);
        chk("stall_map_valid", 0, mv[0], 1);
        @(posedge clk); #1 rmode[0] = 0;
      end
    join
    wait_done(0);
    check_final(0);

    // all-zero matrix
    zero_graph();
    run_model(0, 16);
    begin_graph(0);
    send_entries(0, 16, -1);
    wait_done(0);
    check_final(0);
    chk("zero_edge_count", 0, ecnt[0], 0);

    // reset mid-graph, then full replay
    graph1();
    run_model(0, 6);
    begin_graph(0);
    send_entries(0, 6, -1);
    rst_b = 1'b0;
    exp_len[0] = 0;
    tok[0]++;
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk); #1 rst_b = 1'b1;
    run_model(0, 16);
    begin_graph(0);
    send_entries(0, 16, -1);
    wait_done(0);
    check_final(0);
    chk("replay_edge_count", 0, ecnt[0], 3);
    chk("replay_total_weight", 0, etot[0], 18);

    // small mesh: only two PEs
    run_model(1, 16);
    chk("model_small_len", 1, exp_len[1], 2);
    chk("model_small_rec1", 1, exp_rec[1][1], 5'b01_0_1_0);
    begin_graph(1);
    send_entries(1, 16, -1);
    wait_done(1);
    check_final(1);
    chk("small_overflow", 1, ovf[1], 1);
    chk("small_edge_count", 1, ecnt[1], 3);

    // start during SCAN is ignored
    run_model(0, 16);
    begin_graph(0);
    send_entries(0, 16, 5);
    wait_done(0);
    check_final(0);

    // start in DONE clears results on the next cycle
    @(posedge clk); #1 start_s[1] = 1'b1;
    @(posedge clk); #1 start_s[1] = 1'b0;
    @(negedge clk);
    chk("restart_edge_count", 1, ecnt[1], 0);
    chk("restart_total_weight", 1, etot[1], 0);
    chk("restart_overflow", 1, ovf[1], 0);
    chk("restart_done", 1, dn[1], 0);

    // random graphs with random back-pressure on both meshes
    for (int it = 0; it < 12; it++) begin
      int d;
      d = it % 2;
      rand_graph();
      run_model(d, ents.size());
      rmode[d] = 2;
      begin_graph(d);
      send_entries(d, ents.size(), -1);
      wait_done(d);
      check_final(d);
      rmode[d] = 0;
      @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
